// File: rtl/down_counter_seq.sv
// Loadable, enable-gated down-counter with start/busy/done handshake.
// Counts a start value down to 0, then stops or auto-reloads.
module down_counter_seq #(
  parameter int X = 4,
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [X-1:0] load_val,
  input  logic         en,
  input  logic         reload,
  input  logic         abort,
  output logic [X-1:0] count,
  output logic         busy,
  output logic         done
);

  localparam int unsigned NM1 = N - 1;
  localparam logic [X-1:0] DEF_LV = NM1[X-1:0];

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state;
  logic [X-1:0] lv;
  logic         rl;
  logic [X-1:0] start_val;

  assign start_val = (load_val == '0) ? DEF_LV : load_val;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      lv    <= '0;
      rl    <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (start) begin
      // en is ignored on the start edge; a restart never pulses done
      state <= RUN;
      lv    <= start_val;
      count <= start_val;
      rl    <= reload;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else if (state == RUN && en) begin
      if (count != '0) begin
        count <= count - 1'b1;
        done  <= 1'b0;
      end else begin
        // terminal count: never wraps below zero
        done <= 1'b1;
        if (rl) begin
          count <= lv;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_down_counter_seq.sv
// Bench for down_counter_seq: N=10 and N=1 instances driven by shared
// directed vectors, checked against a period-arithmetic model every cycle.
module tb_down_counter_seq;
  localparam int X = 4;

  logic clk = 1'b0;
  logic reset, start, en, reload, abort;
  logic [X-1:0] load_val;
  logic [X-1:0] count_a, count_b;
  logic busy_a, busy_b, done_a, done_b;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  down_counter_seq #(.X(X), .N(10)) dut_a (
    .clk(clk), .reset(reset), .start(start), .load_val(load_val), .en(en),
    .reload(reload), .abort(abort), .count(count_a), .busy(busy_a), .done(done_a)
  );

  down_counter_seq #(.X(X), .N(1)) dut_b (
    .clk(clk), .reset(reset), .start(start), .load_val(load_val), .en(en),
    .reload(reload), .abort(abort), .count(count_b), .busy(busy_b), .done(done_b)
  );

  // Model: a sequence with start value L is a cycle of L+1 enabled edges;
  // k counts enabled edges since start, count = L - (k mod (L+1)).
  int  nv [2] = '{10, 1};
  bit  m_run [2] = '{0, 0};
  bit  m_done[2] = '{0, 0};
  bit  m_rl  [2] = '{0, 0};
  int  m_L   [2] = '{0, 0};
  int  m_k   [2] = '{0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset || abort) begin
        m_run[i] = 0; m_done[i] = 0;
      end else if (start) begin
        m_L[i] = (load_val == 0) ? nv[i] - 1 : int'(load_val);
        m_rl[i] = reload; m_k[i] = 0; m_run[i] = 1; m_done[i] = 0;
      end else if (m_run[i] && en) begin
        m_k[i]++;
        m_done[i] = (m_k[i] % (m_L[i] + 1)) == 0;
        if (m_done[i] && !m_rl[i]) m_run[i] = 0;
      end else begin
        m_done[i] = 0;
      end
    end
  end

  function automatic int exp_count(int i);
    return m_run[i] ? m_L[i] - (m_k[i] % (m_L[i] + 1)) : 0;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model count a", int'(count_a), exp_count(0));
      chk("model busy a",  int'(busy_a),  int'(m_run[0]));
      chk("model done a",  int'(done_a),  int'(m_done[0]));
      chk("model count b", int'(count_b), exp_count(1));
      chk("model busy b",  int'(busy_b),  int'(m_run[1]));
      chk("model done b",  int'(done_b),  int'(m_done[1]));
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(bit s, int lv, bit e, bit r, bit a);
    start = s; load_val = lv[X-1:0]; en = e; reload = r; abort = a;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    step(2);
    chk_on = 1'b1;
    chk("reset count", int'(count_a), 0);
    chk("reset busy",  int'(busy_a),  0);
    chk("reset done",  int'(done_a),  0);

    // default period: 9..0, done on the 10th enabled edge
    reset = 1'b1;
    drive(1, 0, 1, 0, 0); step();
    chk("default start count", int'(count_a), 9);
    chk("default start busy",  int'(busy_a),  1);
    drive(0, 0, 1, 0, 0); step(9);
    chk("default at zero", int'(count_a), 0);
    chk("default no early done", int'(done_a), 0);
    step();
    chk("default done", int'(done_a), 1);
    chk("default busy drop", int'(busy_a), 0);
    step();
    chk("default done one cycle", int'(done_a), 0);
    chk("default idle count", int'(count_a), 0);

    // auto-reload with en toggling
    drive(1, 3, 1, 1, 0); step();
    chk("reload start count", int'(count_a), 3);
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, (i % 2) == 0, 0, 0); step();
      if (i == 0) chk("reload dec", int'(count_a), 2);
      if (i == 1) chk("reload hold", int'(count_a), 2);
      if (i == 6) begin
        chk("reload done", int'(done_a), 1);
        chk("reload value", int'(count_a), 3);
        chk("reload busy", int'(busy_a), 1);
      end
    end

    // restart mid-sequence at count 5
    drive(1, 9, 1, 0, 0); step();
    drive(0, 0, 1, 0, 0); step(4);
    chk("pre-restart count", int'(count_a), 5);
    drive(1, 7, 1, 0, 0); step();
    chk("restart count", int'(count_a), 7);
    chk("restart no done", int'(done_a), 0);
    chk("restart busy", int'(busy_a), 1);
    drive(0, 0, 1, 0, 0); step();
    chk("restart continues", int'(count_a), 6);

    // abort beats start at count 2
    step(4);
    chk("pre-abort count", int'(count_a), 2);
    drive(1, 5, 1, 0, 1); step();
    chk("abort count", int'(count_a), 0);
    chk("abort busy", int'(busy_a), 0);
    chk("abort done", int'(done_a), 0);
    drive(0, 0, 1, 0, 0); step(3);
    chk("idle en ignored", int'(count_a), 0);

    // reset while busy; start ignored during reset
    drive(1, 4, 0, 0, 0); step();
    chk("pre-reset count", int'(count_a), 4);
    reset = 1'b0; drive(0, 0, 1, 0, 0); step();
    chk("reset mid count", int'(count_a), 0);
    chk("reset mid busy", int'(busy_a), 0);
    drive(1, 6, 1, 0, 0); step();
    chk("start under reset", int'(busy_a), 0);
    reset = 1'b1; step();
    chk("post-reset start", int'(count_a), 6);
    drive(0, 0, 1, 0, 0); step(8);

    // full-width start value, no wrap below zero
    drive(1, 15, 1, 0, 0); step();
    chk("full width", int'(count_a), 15);
    drive(0, 0, 1, 0, 0); step(16);
    chk("full width done", int'(done_a), 1);
    step(2);

    // N=1 with auto-reload: done every enabled cycle until abort
    drive(1, 0, 1, 1, 0); step();
    chk("n1 start done", int'(done_b), 0);
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("n1 pulse done", int'(done_b), 1);
      chk("n1 pulse count", int'(count_b), 0);
    end
    drive(0, 0, 1, 0, 1); step();
    chk("n1 abort done", int'(done_b), 0);
    chk("n1 abort busy", int'(busy_b), 0);
    drive(0, 0, 1, 0, 0); step(3);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/down_counter_seq.md
Name: down_counter_seq

Overview:
- Loadable, enable-gated down-counter with a start/busy/done handshake.
- Counts a loaded value down to 0, then either stops or auto-reloads.
- Companion to the existing modulo up-counter; sequences multiplier iteration steps and display refresh periods where a terminal-count event is needed.
- One clock domain; pure sequential control, no arithmetic beyond decrement.

Parameters:
- X, 4, counter width in bits.
- N, 10, default period; when load_val is 0 at start, the block loads N-1 instead. Requires 1 <= N <= 2^X.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- start  input  1  begin (or restart) a count sequence using load_val.
- load_val  input  X  start value for the sequence; 0 selects N-1.
- en  input  1  count enable; decrement occurs only on enabled cycles.
- reload  input  1  sampled at start; 1 = auto-reload at terminal count, 0 = single shot.
- abort  input  1  terminate the sequence immediately, with no done pulse.
- count  output  X  current count value (registered).
- busy  output  1  high while a sequence is active.
- done  output  1  one-cycle pulse at terminal count (registered).

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-low. All state updates on the rising edge of clk only.
- Reset (reset==0 at a clk edge) has priority over all inputs. It forces:
  - state=IDLE, count=0, busy=0, done=0;
  - latched start value lv=0, latched reload flag rl=0.
- States:
  - IDLE: busy=0, count holds its last value, en is ignored.
  - RUN: busy=1.
- Per-edge priority (after reset): abort > start > en-count.
- abort=1, any state:
  - next state=IDLE; count=0; busy=0; done=0.
  - Simultaneous start is ignored.
- start=1, any state, no abort:
  - lv <= (load_val==0 ? N-1 : load_val); count <= same value; rl <= reload; state=RUN; busy=1; done=0.
  - start while already RUN restarts the sequence and produces no done pulse.
  - en on the start cycle is ignored; no decrement happens that cycle.
- RUN, no start, no abort:
  - en=0: count holds; done=0.
  - en=1 and count>0: count <= count-1; done=0.
  - en=1 and count==0 (terminal): done=1 for exactly that next cycle.
    - rl=1: count <= lv, stay RUN.
    - rl=0: count stays 0, state=IDLE, busy=0.
- Period: for start value L, the sequence takes exactly L+1 enabled cycles from the first post-start enabled edge to the done edge. The count sequence is L, L-1, ..., 0.
  - Default (load_val=0): the count runs N-1..0, giving a period of N enabled cycles. This mirrors the up-counter's 0..N-1.
- done and busy timing:
  - done is never high for two consecutive cycles unless rl=1 and L=0, in which case it pulses every enabled cycle.
  - busy drops in the same cycle done rises in single-shot mode.
- Wrap-around: the count never underflows. Count 0 with en=1 always takes the terminal path, never 2^X-1.
- Width: load_val is taken at full X bits with no truncation. N-1 must fit in X bits (parameter constraint; N > 2^X is illegal).
- Default when the block is idle after a completed sequence: count=0, busy=0, done=0.

Test Plan:
- Reset, then start=1 with load_val=0 (X=4, N=10), en held 1 -> count 9,8,...,0; done=1 on the edge after count==0 (10th enabled edge after start); busy falls with done; count stays 0.
- start with load_val=3, reload=1, en toggling 1,0,1,0 -> count decrements only on en=1 edges (3,3,2,2,1,...); done pulses every 4 enabled cycles; count reloads to 3; busy stays 1.
- Mid-sequence at count=5: assert start with load_val=7 -> count=7 next cycle, no done pulse, busy stays 1; sequence continues from 7.
- At count=2 assert abort and start together -> IDLE, count=0, busy=0, done stays 0; a later en=1 produces no change.
- Assert reset low while busy at count=4 and en=1 -> the next edge gives count=0, busy=0, done=0; start is ignored while reset is low; after reset is released, start works normally.
- start with load_val=0, reload=1, en=1, with N=1 instantiated -> count stays 0 and done=1 every cycle after start until abort=1 clears it.
